div_scheduler: RTL
==================

// Module: div_scheduler
// PURPOSE
//  Shares one integer_div instance among NREQ requesters through round-robin arbitration.
//  Latches the winner's operands and sequences the divider's start/rdy protocol.
//  Returns quotient/remainder with a one-cycle done pulse tagged by requester ID.
//  Sits between the timing-calculation clients and the single shared divider.
// PARAMETERS
//  WIDTH  8  operand/result width; must match the attached integer_div WIDTH
//  NREQ   4  number of requesters, >=2
// PORTS
//  clk            in   1           single clock; all state on rising edge
//  rst            in   1           asynchronous, active-high reset
//  req            in   NREQ        per-requester request level; held until own done
//  req_dividend   in   NREQ*WIDTH  packed dividends, slice i = requester i
//  req_divider    in   NREQ*WIDTH  packed divisors, slice i = requester i
//  done           out  NREQ        one-hot one-cycle completion pulse
//  resp_result    out  WIDTH       quotient, valid while any done bit is high, held after
//  resp_remainder out  WIDTH       remainder, same validity as resp_result
//  resp_id        out  $clog2(NREQ) index of the requester being served or last served
//  busy           out  1           high in LOAD/RUN/DONE
//  div_start      out  1           to integer_div start
//  div_dividend   out  WIDTH       to integer_div dividend (registered)
//  div_divider    out  WIDTH       to integer_div divider (registered)
//  div_result     in   WIDTH       from integer_div result
//  div_remainder  in   WIDTH       from integer_div remainder
//  div_rdy        in   1           from integer_div rdy
// BEHAVIOUR
//  Reset: state=IDLE. done, div_start and busy are 0. resp_*, div_dividend, div_divider and resp_id are 0. RR pointer=NREQ-1, so requester 0 wins first.
//  IDLE: when req!=0, grant the first set bit searching from ptr+1 with wrap-around.
//    Register the winner's operands into div_dividend/div_divider and set resp_id.
//    Set ptr to the winner. Go to LOAD.
//  LOAD (1 cycle): div_start=0, so the divider loads the dividend and clears the remainder. Go to RUN.
//  RUN: div_start=1 until div_rdy=1 is sampled.
//    On that edge, capture div_result/div_remainder into resp_* and go to DONE.
//  DONE (1 cycle): done[resp_id]=1 and div_start=0. Go to IDLE.
//  Latency: grant edge to done pulse = WIDTH+2 cycles, with the exact count set by div_rdy.
//    Throughput: one division every WIDTH+3 cycles under continuous load.
//  A requester whose req is still high in the cycle after its done is treated as a new request.
//  Operand changes on req_* after grant are ignored; the latched copies are used.
//  Simultaneous requests: strict RR, with no requester served twice while another waits.
//  A requester dropping req after grant is still served and still receives its done pulse.
//  Reset mid-operation: immediate return to IDLE with div_start=0. No done pulse; the pending request is lost.
//  div_rdy is ignored outside RUN.
// CONFIGURATION
//  DIV_SCHED_ZERO_CHECK_EN defined:
//    An operand pair with divisor==0 skips LOAD/RUN and goes IDLE->DONE directly, giving 2-cycle latency.
//    resp_result = all ones; resp_remainder = latched dividend; div_start stays 0.
//  Not defined:
//    divisor 0 runs the divider normally, and resp_* is whatever integer_div produces (quotient all ones).
//    Timing is the same as for nonzero divisors.
// STRUCTURE
//  Package math_pkg: typedef enum logic [1:0] {S_IDLE,S_LOAD,S_RUN,S_DONE} div_sched_state_t.
//    It also holds the function rr_pick(req, ptr) returning the winner index.
//  Sub-module rr_arbiter #(NREQ): combinational pick plus registered pointer.
//    Pointer update is enabled only on grant.
// TESTING (WIDTH=8, NREQ=4, integer_div attached)
//  1. req=0001, 100/7 -> done=0001 once, result=14, rem=2, resp_id=0, latency WIDTH+2.
//  2. req=0110 same cycle, operands 200/9 and 50/5 -> id1 (22,2) first, then id2 (10,0); no overlap.
//  3. req=1111 held continuously for 8 divisions -> grant order 0,1,2,3,0,1,2,3.
//  4. rst pulsed in mid-RUN -> no done; outputs reset; next request 255/16 -> 15, rem 15.
//  5. 37/0 -> with macro: 2-cycle done, result=255, rem=37, div_start never high;
//     without macro: normal latency.
//  6. Operands changed after grant, and req dropped in RUN -> done still pulses with the original operands' result.

Source files
------------

// File: rtl/math_pkg.sv
// Shared types and helpers for the divider scheduler.
// Holds the FSM state encoding and the round-robin pick function.
package math_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } div_sched_state_t;

    localparam int unsigned RR_MAX = 32;

    // Winner = first set bit searching from ptr+1 upward, wrapping at nreq.
    function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                            input int unsigned       ptr,
                                            input int unsigned       nreq);
        int unsigned win;
        int unsigned idx;
        win = ptr;
        for (int unsigned i = nreq; i >= 1; i--) begin
            idx = (ptr + i) % nreq;
            if (req[idx[4:0]]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick from a registered pointer.
// The pointer only moves to the winner when the grant is taken.
module rr_arbiter
    import math_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic                     grant,
    output logic [$clog2(NREQ)-1:0]  pick_c,
    output logic                     any_c
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr;

    always_comb begin
        pick_c = IDW'(rr_pick(RR_MAX'(req), 32'(ptr), NREQ));
        any_c  = |req;
    end

    // Reset to NREQ-1 so requester 0 is favoured first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IDW'(NREQ - 1);
        end else if (grant) begin
            ptr <= pick_c;
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Shares one integer_div among NREQ requesters with round-robin arbitration.
// Optional DIV_SCHED_ZERO_CHECK_EN short-circuits divide-by-zero without using the divider.
module div_scheduler
    import math_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_dividend,
    input  logic [NREQ*WIDTH-1:0]    req_divider,
    output logic [NREQ-1:0]          done,
    output logic [WIDTH-1:0]         resp_result,
    output logic [WIDTH-1:0]         resp_remainder,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic                     busy,
    output logic                     div_start,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divider,
    input  logic [WIDTH-1:0]         div_result,
    input  logic [WIDTH-1:0]         div_remainder,
    input  logic                     div_rdy
);

    localparam int unsigned IDW = $clog2(NREQ);

    div_sched_state_t state, state_d;

    logic [IDW-1:0]   pick_c;
    logic             any_c;
    logic             grant_c;
    logic [WIDTH-1:0] win_dividend_c;
    logic [WIDTH-1:0] win_divider_c;

    logic [NREQ-1:0]  done_d;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] rem_d;
    logic [IDW-1:0]   id_d;
    logic             busy_d;
    logic             start_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] dvs_d;

    assign grant_c        = (state == S_IDLE) && any_c;
    assign win_dividend_c = req_dividend[32'(pick_c) * WIDTH +: WIDTH];
    assign win_divider_c  = req_divider[32'(pick_c) * WIDTH +: WIDTH];

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .grant  (grant_c),
        .pick_c (pick_c),
        .any_c  (any_c)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d = state;
        res_d   = resp_result;
        rem_d   = resp_remainder;
        id_d    = resp_id;
        dvd_d   = div_dividend;
        dvs_d   = div_divider;
        done_d  = '0;
        busy_d  = 1'b0;
        start_d = 1'b0;

        case (state)
            S_IDLE: begin
                if (any_c) begin
                    dvd_d   = win_dividend_c;
                    dvs_d   = win_divider_c;
                    id_d    = pick_c;
                    state_d = S_LOAD;
`ifdef DIV_SCHED_ZERO_CHECK_EN
                    if (win_divider_c == '0) begin
                        res_d   = '1;
                        rem_d   = win_dividend_c;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (div_rdy) begin
                    res_d   = div_result;
                    rem_d   = div_remainder;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they align with it.
        busy_d  = (state_d != S_IDLE);
        start_d = (state_d == S_RUN);
        if (state_d == S_DONE) begin
            done_d = NREQ'(1) << id_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            done           <= '0;
            resp_result    <= '0;
            resp_remainder <= '0;
            resp_id        <= '0;
            busy           <= 1'b0;
            div_start      <= 1'b0;
            div_dividend   <= '0;
            div_divider    <= '0;
        end else begin
            state          <= state_d;
            done           <= done_d;
            resp_result    <= res_d;
            resp_remainder <= rem_d;
            resp_id        <= id_d;
            busy           <= busy_d;
            div_start      <= start_d;
            div_dividend   <= dvd_d;
            div_divider    <= dvs_d;
        end
    end

endmodule
